// File: rtl/ffo32s_decoder.sv
// Sequential find-first-one decoder: rebuilds the MSB-first one-hot word for
// (v, p) by walking a single one down the vector, one bit per clock.
module ffo32s_decoder #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         v,
  input  logic [0:W-1] p,
  output logic [0:N-1] b,
  output logic         ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [0:W-1] r_cnt;
  logic [0:W-1] w_cnt_nxt;
  logic [0:N-1] r_b;
  logic [0:N-1] w_b_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_b     <= w_b_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_b_nxt     = r_b;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SHIFT;
          if (v) begin
            w_b_nxt   = {1'b1, {(N-1){1'b0}}};
            w_cnt_nxt = p;
          end else begin
            w_b_nxt   = '0;
            w_cnt_nxt = '0;
          end
        end
      end
      SHIFT: begin
        // On a [0:N-1] vector >> moves the one toward higher index.
        if (r_cnt != '0) begin
          w_b_nxt   = r_b >> 1;
          w_cnt_nxt = r_cnt - W'(1);
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign b     = r_b;
  assign ready = (r_state == IDLE);

endmodule

// File: tb/tb_ffo32s_decoder.sv
// Directed bench for ffo32s_decoder: reset, latency extremes, invalid input,
// randomised-handshake sweep with FFO round-trip, back-to-back and mid-op reset.
module tb_ffo32s_decoder;

  logic        clock;
  logic        reset;
  logic        start;
  logic        v;
  logic [4:0]  p;
  logic [0:31] b;
  logic        ready;

  int n_total = 0;
  int n_bad   = 0;

  ffo32s_decoder #(.N(32), .W(5)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .v     (v),
    .p     (p),
    .b     (b),
    .ready (ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference combinational FFO32 over an MSB-first word: {valid, position}.
  function automatic logic [5:0] ffo32(input logic [0:31] w);
    for (int i = 0; i < 32; i++)
      if (w[i]) return {1'b1, 5'(i)};
    return 6'd0;
  endfunction

  // One operation: start at the next rising edge, optionally keep start high,
  // optionally disturb v/p during SHIFT, then check latency and result.
  task automatic op(input logic iv, input logic [4:0] ip, input bit hold,
                    input bit scramble, input int lat_exp,
                    input logic [31:0] b_exp, input string tag);
    int n;
    @(negedge clock);
    start = 1'b1;
    v     = iv;
    p     = ip;
    @(posedge clock); #1;
    check({tag, "_busy"}, {31'd0, ready}, 32'd0);
    if (!hold) start = 1'b0;
    if (scramble) begin
      v = 1'b0;
      p = ip ^ 5'h1a;
    end
    n = 0;
    while (!ready && n <= lat_exp + 1) begin
      @(posedge clock); #1;
      n++;
    end
    check({tag, "_lat"}, n, lat_exp);
    check({tag, "_b"}, b, b_exp);
    check({tag, "_ffo"}, {26'd0, ffo32(b)}, iv ? {26'd0, 1'b1, ip} : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b1;
    v     = 1'b1;
    p     = 5'd9;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_b", b, 32'h0000_0000);
    repeat (2) @(posedge clock);
    #1;
    check("rst_hold_ready", {31'd0, ready}, 32'd1);
    check("rst_hold_b", b, 32'h0000_0000);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    check("post_rst_ready", {31'd0, ready}, 32'd1);
    check("post_rst_b", b, 32'h0000_0000);

    op(1'b1, 5'd0,  1'b0, 1'b0, 1,  32'h8000_0000, "min_lat");
    op(1'b1, 5'd31, 1'b0, 1'b1, 32, 32'h0000_0001, "max_lat");
    op(1'b0, 5'd17, 1'b0, 1'b0, 1,  32'h0000_0000, "invalid");
    op(1'b1, 5'd7,  1'b0, 1'b0, 8,  32'h0100_0000, "p7");

    for (int i = 0; i < 32; i++) begin
      bit hold;
      int gap;
      hold = 1'($urandom_range(0, 1));
      op(1'b1, i[4:0], hold, 1'b1, i + 1, 32'h8000_0000 >> i, "sweep");
      gap = $urandom_range(0, 4);
      if (gap > 0) begin
        start = 1'b0;
        repeat (gap) @(posedge clock);
      end
    end

    op(1'b1, 5'd4,  1'b1, 1'b1, 5,  32'h0800_0000, "b2b_a");
    op(1'b1, 5'd12, 1'b1, 1'b1, 13, 32'h0008_0000, "b2b_b");
    op(1'b0, 5'd9,  1'b1, 1'b1, 1,  32'h0000_0000, "b2b_c");
    op(1'b1, 5'd1,  1'b1, 1'b1, 2,  32'h4000_0000, "b2b_d");
    start = 1'b0;
    @(posedge clock);

    @(negedge clock);
    start = 1'b1;
    v     = 1'b1;
    p     = 5'd20;
    @(posedge clock); #1;
    start = 1'b0;
    check("mid_busy", {31'd0, ready}, 32'd0);
    repeat (5) @(posedge clock);
    #2;
    check("mid_pre_rst_b", b, 32'h0400_0000);
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ready}, 32'd1);
    check("mid_rst_b", b, 32'h0000_0000);
    @(negedge clock);
    reset = 1'b1;
    op(1'b1, 5'd3, 1'b0, 1'b0, 4, 32'h1000_0000, "after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
